core_run_ctrl: RTL and testbench

Parametrised run controller for 9x8 processor cores in simulation and bring-up builds. Holds one or more cores in reset for a programmable number of cycles, releases them in staggered order, runs them for a bounded number of cycles, and reports pass, timeout or abort. Sits between the top-level clock/reset and the `i_rst` inputs of N core instances; it replaces fixed reset-then-finish sequencing with one reusable, multi-channel, observable block.

---
 rtl/core_run_ctrl_if.sv | 40 ++++
 rtl/core_run_ctrl.sv | 161 ++++++++++++++++
 tb/tb_core_run_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/core_run_ctrl_if.sv
// Request/status bundle between a run controller and its driver.
// o_cycles (and CNT_WIDTH) exist only when CORE_RUN_CTRL_CYCLES_EN is defined.
interface core_run_ctrl_if #(
    parameter int unsigned N_CH = 1
`ifdef CORE_RUN_CTRL_CYCLES_EN
    ,
    parameter int unsigned CNT_WIDTH = 16
`endif
);
    logic            i_start;
    logic            i_abort;
    logic [N_CH-1:0] i_done;
    logic [N_CH-1:0] o_core_rst;
    logic            o_running;
    logic            o_finished;
    logic            o_pass;
    logic            o_timeout;
    logic            o_aborted;
`ifdef CORE_RUN_CTRL_CYCLES_EN
    logic [CNT_WIDTH-1:0] o_cycles;

    modport master (
        output i_start, i_abort, i_done,
        input  o_core_rst, o_running, o_finished, o_pass, o_timeout, o_aborted, o_cycles
    );
    modport slave (
        input  i_start, i_abort, i_done,
        output o_core_rst, o_running, o_finished, o_pass, o_timeout, o_aborted, o_cycles
    );
`else
    modport master (
        output i_start, i_abort, i_done,
        input  o_core_rst, o_running, o_finished, o_pass, o_timeout, o_aborted
    );
    modport slave (
        input  i_start, i_abort, i_done,
        output o_core_rst, o_running, o_finished, o_pass, o_timeout, o_aborted
    );
`endif
endinterface

// File: rtl/core_run_ctrl.sv
// Multi-channel core run controller: staggered reset release, bounded run, pass/timeout/abort.
// Define CORE_RUN_CTRL_CYCLES_EN to add the o_cycles run-length capture.
module core_run_ctrl #(
    parameter int unsigned N_CH       = 1,
    parameter int unsigned RST_CYCLES = 5,
    parameter int unsigned STAGGER    = 0,
    parameter int unsigned RUN_CYCLES = 69,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic           i_clk,
    input  logic           i_rst,
    core_run_ctrl_if.slave bus
);
    localparam int unsigned RstMax  = RST_CYCLES + (N_CH - 1) * STAGGER;
    localparam int unsigned CntNeed = (RstMax > RUN_CYCLES) ? RstMax : RUN_CYCLES;
    localparam longint unsigned CntMax = (64'd1 << CNT_WIDTH) - 64'd1;

    if (N_CH < 1 || N_CH > 16) begin : g_bad_n_ch
        $error("core_run_ctrl: N_CH must be in 1..16");
    end
    if (RST_CYCLES < 1 || RUN_CYCLES < 1) begin : g_bad_cycles
        $error("core_run_ctrl: RST_CYCLES and RUN_CYCLES must be at least 1");
    end
    if (CNT_WIDTH < 1 || CNT_WIDTH > 32 || longint'(CntNeed) > CntMax) begin : g_bad_width
        $error("core_run_ctrl: CNT_WIDTH too small for reset/run cycle counts");
    end

    typedef enum logic [1:0] {StIdle, StReset, StRun, StDone} state_e;
    typedef logic [CNT_WIDTH-1:0] cnt_t;

    state_e          state_q, state_d;
    cnt_t            cnt_q, cnt_d, cnt_inc;
    logic [N_CH-1:0] mask_q, mask_d, mask_now;
    logic [N_CH-1:0] core_rst_q, core_rst_d;
    logic            running_q, running_d;
    logic            finished_q, finished_d;
    logic            pass_q, pass_d;
    logic            timeout_q, timeout_d;
    logic            aborted_q, aborted_d;
`ifdef CORE_RUN_CTRL_CYCLES_EN
    cnt_t            cycles_q, cycles_d;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        core_rst_d = core_rst_q;
        running_d  = running_q;
        finished_d = finished_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        aborted_d  = aborted_q;
`ifdef CORE_RUN_CTRL_CYCLES_EN
        cycles_d   = cycles_q;
`endif
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + cnt_t'(1);
        mask_now   = mask_q | bus.i_done;

        unique case (state_q)
            StIdle: begin
                if (bus.i_start) begin
                    state_d = StReset;
                    cnt_d   = '0;
                end
            end
            StReset: begin
                cnt_d = cnt_inc;
                // cnt_q counts edges since start minus one, so release on threshold-1
                for (int k = 0; k < N_CH; k++) begin
                    if (cnt_q >= cnt_t'(RST_CYCLES + k * STAGGER - 1)) core_rst_d[k] = 1'b0;
                end
                if (bus.i_abort) begin
                    state_d    = StDone;
                    core_rst_d = '1;
                    finished_d = 1'b1;
                    aborted_d  = 1'b1;
`ifdef CORE_RUN_CTRL_CYCLES_EN
                    cycles_d   = '0;
`endif
                end else if (cnt_q >= cnt_t'(RstMax - 1)) begin
                    state_d   = StRun;
                    cnt_d     = '0;
                    running_d = 1'b1;
                end
            end
            StRun: begin
                cnt_d  = cnt_inc;
                mask_d = mask_now;
                if (bus.i_abort || (&mask_now) || cnt_q >= cnt_t'(RUN_CYCLES - 1)) begin
                    state_d    = StDone;
                    core_rst_d = '1;
                    running_d  = 1'b0;
                    finished_d = 1'b1;
                    aborted_d  = bus.i_abort;
                    pass_d     = !bus.i_abort && (&mask_now);
                    timeout_d  = !bus.i_abort && !(&mask_now);
`ifdef CORE_RUN_CTRL_CYCLES_EN
                    cycles_d   = cnt_q;
`endif
                end
            end
            StDone: begin
                if (bus.i_start) begin
                    state_d    = StReset;
                    cnt_d      = '0;
                    mask_d     = '0;
                    finished_d = 1'b0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    aborted_d  = 1'b0;
`ifdef CORE_RUN_CTRL_CYCLES_EN
                    cycles_d   = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            mask_q     <= '0;
            core_rst_q <= '1;
            running_q  <= 1'b0;
            finished_q <= 1'b0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
            aborted_q  <= 1'b0;
`ifdef CORE_RUN_CTRL_CYCLES_EN
            cycles_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mask_q     <= mask_d;
            core_rst_q <= core_rst_d;
            running_q  <= running_d;
            finished_q <= finished_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
            aborted_q  <= aborted_d;
`ifdef CORE_RUN_CTRL_CYCLES_EN
            cycles_q   <= cycles_d;
`endif
        end
    end

    assign bus.o_core_rst = core_rst_q;
    assign bus.o_running  = running_q;
    assign bus.o_finished = finished_q;
    assign bus.o_pass     = pass_q;
    assign bus.o_timeout  = timeout_q;
    assign bus.o_aborted  = aborted_q;
`ifdef CORE_RUN_CTRL_CYCLES_EN
    assign bus.o_cycles   = cycles_q;
`endif

endmodule

// File: tb/tb_core_run_ctrl.sv
// Bench for core_run_ctrl: directed and random runs checked against a timeline model
// that derives every output from event times (start, release, done, abort, reset).
module tb_core_run_ctrl;
    localparam int unsigned N_CH       = 2;
    localparam int unsigned RST_CYCLES = 5;
    localparam int unsigned STAGGER    = 3;
    localparam int unsigned RUN_CYCLES = 69;
    localparam int unsigned CNT_WIDTH  = 16;
    localparam int          R_MAX      = RST_CYCLES + (N_CH - 1) * STAGGER;
    localparam int          INF        = 100000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    core_run_ctrl_if #(
        .N_CH(N_CH)
`ifdef CORE_RUN_CTRL_CYCLES_EN
        ,
        .CNT_WIDTH(CNT_WIDTH)
`endif
    ) bus ();

    core_run_ctrl #(
        .N_CH      (N_CH),
        .RST_CYCLES(RST_CYCLES),
        .STAGGER   (STAGGER),
        .RUN_CYCLES(RUN_CYCLES),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .i_clk(clk),
        .i_rst(rst_n),
        .bus  (bus)
    );

    // Outputs expected t edges after the start edge, from the run's resolved event times.
    function automatic logic [N_CH+4:0] model(input int t, input int tend, input int outcome,
                                              input int rt);
        logic [N_CH-1:0] crst;
        logic run, fin, ps, to, ab;
        crst = '1;
        run = 1'b0; fin = 1'b0; ps = 1'b0; to = 1'b0; ab = 1'b0;
        if (rt >= 1 && t >= rt) begin
            crst = '1;
        end else if (t >= tend) begin
            fin = 1'b1;
            ps  = (outcome == 1);
            to  = (outcome == 2);
            ab  = (outcome == 3);
        end else begin
            for (int k = 0; k < N_CH; k++) crst[k] = (t < int'(RST_CYCLES + k * STAGGER));
            run = (t >= R_MAX);
        end
        return {crst, run, fin, ps, to, ab};
    endfunction

    task automatic check_out(input string tag, input int t, input logic [N_CH+4:0] exp);
        logic [N_CH+4:0] obs;
        obs = {bus.o_core_rst, bus.o_running, bus.o_finished, bus.o_pass, bus.o_timeout,
               bus.o_aborted};
        checks++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s t=%0d observed rst/run/fin/pass/to/ab=%b expected %b",
                   tag, t, obs, exp);
        end
    endtask

    // One start-to-finish run; dt*/at/rt are edge offsets from the start edge, <1 means none.
    task automatic run_case(input string tag, input int dt0, input int dt1, input int at,
                            input int rt, input bit noise);
        int f0, f1, tpass, ttime, tab, tend, outcome, last_t;
        f0     = (dt0 > R_MAX) ? dt0 : INF;
        f1     = (dt1 > R_MAX) ? dt1 : INF;
        tpass  = (f0 < INF && f1 < INF) ? ((f0 > f1) ? f0 : f1) : INF;
        ttime  = R_MAX + RUN_CYCLES;
        tab    = (at >= 1) ? at : INF;
        tend   = tab;
        if (tpass < tend) tend = tpass;
        if (ttime < tend) tend = ttime;
        outcome = (tab == tend) ? 3 : (tpass == tend) ? 1 : 2;
        last_t = ((rt > tend) ? rt : tend) + 3;

        bus.i_start = 1'b1;
        bus.i_abort = 1'b0;
        bus.i_done  = '0;
        @(posedge clk);
        #1;
        check_out(tag, 0, model(0, tend, outcome, rt));
        for (int t = 1; t <= last_t; t++) begin
            bus.i_start = noise && t <= tend && (rt < 1 || t < rt) && ($urandom_range(0, 3) == 0);
            bus.i_abort = (t == at);
            bus.i_done[0] = (t == dt0);
            bus.i_done[1] = (t == dt1);
            rst_n = !(t == rt);
            @(posedge clk);
            #1;
            check_out(tag, t, model(t, tend, outcome, rt));
`ifdef CORE_RUN_CTRL_CYCLES_EN
            begin
                int ec;
                ec = 0;
                if (!(rt >= 1 && t >= rt) && t >= tend) begin
                    if (outcome == 1) ec = tpass - R_MAX - 1;
                    else if (outcome == 2) ec = RUN_CYCLES - 1;
                    else ec = (at > R_MAX) ? at - R_MAX - 1 : 0;
                end
                checks++;
                assert (bus.o_cycles === CNT_WIDTH'(ec)) begin
                    passed++;
                end else begin
                    $error("FAIL %s_cycles t=%0d observed %0d expected %0d",
                           tag, t, bus.o_cycles, ec);
                end
            end
`endif
        end
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_done  = '0;
        rst_n       = 1'b1;
    endtask

    initial begin
        logic [N_CH+4:0] idle_vec;
        idle_vec = {{N_CH{1'b1}}, 5'b00000};
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        bus.i_done  = '1;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_out("reset", 0, idle_vec);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        bus.i_done  = '0;
        rst_n       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_out("idle_hold", 0, idle_vec);

        run_case("timeout", -1, -1, -1, -1, 1'b0);
        run_case("pass", 10, 20, -1, -1, 1'b0);
        run_case("done_in_reset", 10, 6, -1, -1, 1'b0);
        run_case("done_first_edge", R_MAX, R_MAX + 1, -1, -1, 1'b0);
        run_case("pass_edge1", R_MAX + 1, R_MAX + 1, -1, -1, 1'b0);
        run_case("pass_on_timeout", R_MAX + RUN_CYCLES, R_MAX + RUN_CYCLES, -1, -1, 1'b0);
        run_case("abort_on_timeout", R_MAX + RUN_CYCLES, R_MAX + RUN_CYCLES,
                 R_MAX + RUN_CYCLES, -1, 1'b0);
        run_case("abort_in_reset", 10, 20, 3, -1, 1'b0);
        run_case("abort_in_run", 10, -1, 15, -1, 1'b0);
        run_case("rst_in_run", 10, 40, -1, 30, 1'b0);
        run_case("after_rst", 10, 20, -1, -1, 1'b0);
        run_case("start_noise", 12, 50, -1, -1, 1'b1);

        for (int i = 0; i < 30; i++) begin
            int d0, d1, a, r;
            d0 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 85));
            d1 = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, 85));
            a  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 80)) : -1;
            r  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 80)) : -1;
            run_case($sformatf("rand%0d", i), d0, d1, a, r, 1'b1);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
